// File: rtl/sm_pkg.sv
// sm -- shared types for the sm_res -> sm_cmd pointer bridge.
// Holds the default pointer width, the packed result/command layouts
// and a saturating 16-bit increment used by the optional counters.
package sm;

    localparam int PTR_W_DEFAULT = 8;

    typedef struct packed {
        logic                     ok;
        logic [PTR_W_DEFAULT-1:0] ptr;
    } sm_res_t;

    typedef struct packed {
        logic                     free_after_read;
        logic [PTR_W_DEFAULT-1:0] ptr;
    } sm_cmd_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/sm_ptr_fifo.sv
// sm_ptr_fifo -- pointer queue for sm_res2cmd.
// Power-of-two depth, read/write pointers carry one extra MSB so full and
// empty are told apart without a separate counter. Storage is not reset.
module sm_ptr_fifo
    import sm::*;
#(
    parameter int W     = PTR_W_DEFAULT + 1,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [W-1:0]             data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level_o = wr_ptr - rd_ptr;
    assign data_o  = mem[rd_ptr[AW-1:0]];

    // Storage write; a flushed push may land here but is never exposed.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= data_i;
        end
    end

    // Pointer update: flush wins over any same-cycle push or pop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/sm_res2cmd.sv
// sm_res2cmd -- turns write-side results into read-side commands.
// Results with ok=1 queue {free_i, ptr}; ok=0 results are swallowed.
// Optional feature macro: SM_RES2CMD_CNT_EN adds saturating forward/drop
// counters (cnt_fwd_o, cnt_drop_o).
module sm_res2cmd
    import sm::*;
#(
    parameter int PTR_W      = PTR_W_DEFAULT,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          sm_res_valid_i,
    input  logic [PTR_W:0]                sm_res_data_i,
    output logic                          sm_res_ready_o,
    output logic                          sm_cmd_valid_o,
    output logic [PTR_W:0]                sm_cmd_data_o,
    input  logic                          sm_cmd_ready_i,
    input  logic                          free_i,
    input  logic                          flush_i,
`ifdef SM_RES2CMD_CNT_EN
    output logic [15:0]                   cnt_fwd_o,
    output logic [15:0]                   cnt_drop_o,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    logic             full;
    logic             empty;
    logic             res_fire;
    logic             res_ok;
    logic             push;
    logic             pop;
    logic [PTR_W:0]   push_data;

    assign res_ok         = sm_res_data_i[PTR_W];
    assign sm_res_ready_o = !full && !flush_i;
    assign res_fire       = sm_res_valid_i && sm_res_ready_o;
    assign push           = res_fire && res_ok;
    assign push_data      = {free_i, sm_res_data_i[PTR_W-1:0]};
    assign sm_cmd_valid_o = !empty;
    assign pop            = sm_cmd_valid_o && sm_cmd_ready_i;

    sm_ptr_fifo #(
        .W     (PTR_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .flush_i (flush_i),
        .data_o  (sm_cmd_data_o),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level_o)
    );

`ifdef SM_RES2CMD_CNT_EN
    // Count forwarded pointers; flush does not clear the count.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)  cnt_fwd_o <= '0;
        else if (push) cnt_fwd_o <= sat_inc16(cnt_fwd_o);
    end

    // Count accepted ok=0 results that were discarded.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                 cnt_drop_o <= '0;
        else if (res_fire && !res_ok) cnt_drop_o <= sat_inc16(cnt_drop_o);
    end
`endif

endmodule

// File: tb/tb_sm_res2cmd.sv
// tb_sm_res2cmd -- randomized bench for sm_res2cmd against a queue model.
// Build with SM_RES2CMD_CNT_EN defined to also check the counters.
module tb_sm_res2cmd;
    import sm::*;

    localparam int PW    = 8;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          res_valid;
    logic [PW:0]   res_data;
    logic          res_ready;
    logic          cmd_valid;
    logic [PW:0]   cmd_data;
    logic          cmd_ready;
    logic          free;
    logic          flush;
    logic [3:0]    level;
`ifdef SM_RES2CMD_CNT_EN
    logic [15:0]   cnt_fwd;
    logic [15:0]   cnt_drop;
`endif

    sm_res2cmd #(.PTR_W(PW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .sm_res_valid_i (res_valid),
        .sm_res_data_i  (res_data),
        .sm_res_ready_o (res_ready),
        .sm_cmd_valid_o (cmd_valid),
        .sm_cmd_data_o  (cmd_data),
        .sm_cmd_ready_i (cmd_ready),
        .free_i         (free),
        .flush_i        (flush),
`ifdef SM_RES2CMD_CNT_EN
        .cnt_fwd_o      (cnt_fwd),
        .cnt_drop_o     (cnt_drop),
`endif
        .level_o        (level)
    );

    always #5 clk = ~clk;

    int        errs = 0;
    int        checks = 0;
    logic [PW:0] q[$];
    int        fwd_m = 0;
    int        drop_m = 0;
    bit        took;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic offer(input bit v, input bit ok, input logic [PW-1:0] p, input bit f);
        sm_res_t r;
        r.ok      = ok;
        r.ptr     = p;
        res_valid = v;
        res_data  = r;
        free      = f;
    endtask

    // Check outputs against the queue model, then advance one clock.
    task automatic step();
        bit rdy_e;
        bit vld_e;
        #1;
        rdy_e = (q.size() < DEPTH) && !flush;
        vld_e = (q.size() != 0);
        chk("res_ready", 32'(res_ready), 32'(rdy_e));
        chk("cmd_valid", 32'(cmd_valid), 32'(vld_e));
        chk("level", 32'(level), 32'(q.size()));
        if (vld_e) chk("cmd_data", 32'(cmd_data), 32'(q[0]));
`ifdef SM_RES2CMD_CNT_EN
        chk("cnt_fwd", 32'(cnt_fwd), 32'(fwd_m));
        chk("cnt_drop", 32'(cnt_drop), 32'(drop_m));
`endif
        took = 1'b0;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (vld_e && cmd_ready) void'(q.pop_front());
            if (res_valid && rdy_e) begin
                took = 1'b1;
                if (res_data[PW]) begin
                    q.push_back({free, res_data[PW-1:0]});
                    if (fwd_m < 65535) fwd_m++;
                end else if (drop_m < 65535) begin
                    drop_m++;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; cmd_ready = 1'b0; flush = 1'b0;
        offer(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 32'(cmd_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_ready", 32'(res_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ok 1, drop 9, ok 2
        cmd_ready = 1'b1;
        offer(1, 1, 8'd1, 0); step();
        offer(1, 0, 8'd9, 1); step();
        offer(1, 1, 8'd2, 1); step();
        offer(0, 0, 0, 0);
        repeat (3) step();
`ifdef SM_RES2CMD_CNT_EN
        chk("fwd_is_2", 32'(cnt_fwd), 2);
        chk("drop_is_1", 32'(cnt_drop), 1);
`endif

        // 3, 5, 7 with ready=1
        offer(1, 1, 8'd3, 0); step();
        offer(1, 1, 8'd5, 1); step();
        offer(1, 1, 8'd7, 0); step();
        offer(0, 0, 0, 0);
        repeat (3) step();

        // fill to full, hold off a 9th, then drain
        cmd_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            offer(1, 1, 8'(16 + i), i[0]);
            step();
        end
        offer(1, 1, 8'd99, 1);
        repeat (3) step();
        chk("full_level", 32'(level), DEPTH);
        chk("full_ready", 32'(res_ready), 0);
        cmd_ready = 1'b1;
        for (int i = 0; i < 20 && !took; i++) step();
        chk("ninth_taken", 32'(took), 1);
        offer(0, 0, 0, 0);
        repeat (DEPTH + 2) step();

        // level 4 with simultaneous push/pop across pointer wrap
        cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(1, 1, 8'(40 + i), 0);
            step();
        end
        cmd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            offer(1, 1, 8'($urandom_range(0, 255)), 1'($urandom));
            step();
        end
        chk("steady_level", 32'(level), 4);
        offer(0, 0, 0, 0);
        repeat (6) step();

        // flush at level 5 with a same-cycle push offered
        cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            offer(1, 1, 8'(60 + i), 0);
            step();
        end
        flush = 1'b1;
        offer(1, 1, 8'd77, 1);
        step();
        flush = 1'b0;
        offer(0, 0, 0, 0);
        #1;
        chk("flush_level", 32'(level), 0);
        chk("flush_valid", 32'(cmd_valid), 0);
        cmd_ready = 1'b1;
        repeat (2) step();

        // random traffic
        for (int i = 0; i < 300; i++) begin
            offer(1'($urandom), ($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom));
            cmd_ready = 1'($urandom);
            flush     = ($urandom_range(0, 19) == 0);
            step();
        end
        flush = 1'b0;

        // async reset mid-stream
        cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(1, 1, 8'(80 + i), 0);
            step();
        end
        offer(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(cmd_valid), 0);
        chk("arst_level", 32'(level), 0);
        chk("arst_ready", 32'(res_ready), 1);
`ifdef SM_RES2CMD_CNT_EN
        chk("arst_fwd", 32'(cnt_fwd), 0);
`endif
        @(posedge clk);
        #2 rst_n = 1'b1;
        q.delete();
        fwd_m = 0;
        drop_m = 0;
        @(negedge clk);
        cmd_ready = 1'b1;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sm_res2cmd.md
SM_RES2CMD -- requirements
Module: sm_res2cmd

Interface
REQ-001 The block SHALL have parameter PTR_W, default 8: pointer width of the sm_res/sm_cmd data.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8: pointer queue depth, a power of two, at least 2.
REQ-003 The block SHALL have port clk_i, input, 1: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst_n_i, input, 1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port sm_res_valid_i, input, 1: a write-side result is offered.
REQ-006 The block SHALL have port sm_res_data_i, input, PTR_W+1: bit PTR_W is ok, bits PTR_W-1:0 are ptr.
REQ-007 The block SHALL have port sm_res_ready_o, output, 1: the block accepts a result.
REQ-008 The block SHALL have port sm_cmd_valid_o, output, 1: a read command is offered.
REQ-009 The block SHALL have port sm_cmd_data_o, output, PTR_W+1: bit PTR_W is free_after_read, bits PTR_W-1:0 are ptr.
REQ-010 The block SHALL have port sm_cmd_ready_i, input, 1: the read side accepts the command.
REQ-011 The block SHALL have port free_i, input, 1: sampled on push; stored as free_after_read with each pointer.
REQ-012 The block SHALL have port flush_i, input, 1: synchronous flush of all queued pointers.
REQ-013 The block SHALL have port level_o, output, $clog2(FIFO_DEPTH)+1: current queue occupancy.

Function
REQ-014 A result transfer SHALL occur when sm_res_valid_i and sm_res_ready_o are both 1 on a rising edge; a command transfer SHALL occur when sm_cmd_valid_o and sm_cmd_ready_i are both 1.
REQ-015 sm_res_ready_o SHALL equal !full && !flush_i, registered-free (combinational from internal state and flush_i only, never from sm_res_valid_i).
REQ-016 An accepted result with ok=1 SHALL push {free_i, ptr}; an accepted result with ok=0 SHALL be consumed and discarded without a push.
REQ-017 sm_cmd_valid_o SHALL equal !empty; sm_cmd_data_o SHALL show the FIFO head and stay stable while sm_cmd_valid_o=1 and sm_cmd_ready_i=0.
REQ-018 Latency SHALL be one cycle: a push at edge N into an empty queue gives sm_cmd_valid_o=1 after edge N, with no combinational bypass from input to output.
REQ-019 Simultaneous push and pop SHALL leave level_o unchanged and preserve FIFO order, including when level_o = FIFO_DEPTH-1 or 1.
REQ-020 When full (level_o = FIFO_DEPTH), sm_res_ready_o SHALL be 0 even if a pop occurs in the same cycle.
REQ-021 Read and write pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be resolved with one extra MSB on the pointers.
REQ-022 flush_i=1 SHALL set level_o to 0 at the next edge, override any same-cycle push and pop, and give sm_cmd_valid_o=0 the cycle after.

Reset
REQ-023 rst_n_i=0 SHALL asynchronously force empty, level_o=0, sm_cmd_valid_o=0, sm_res_ready_o=1 (after deassertion), counters=0; FIFO storage is not reset.
REQ-024 Reset asserted mid-transfer SHALL discard all queued pointers; no command is reissued after release.

Configuration
REQ-025 With macro SM_RES2CMD_CNT_EN defined, the block SHALL add outputs cnt_fwd_o[15:0] (pushes) and cnt_drop_o[15:0] (ok=0 results); both SHALL saturate at 16'hFFFF, clear on reset, and ignore flush_i.
REQ-026 Without SM_RES2CMD_CNT_EN, the block SHALL have no counter ports and no counter logic.

Structure
REQ-027 Package sm SHALL hold the typedefs sm_res_t {ok, ptr} and sm_cmd_t {free_after_read, ptr}, and the PTR_W default.
REQ-028 Queue storage and pointers SHALL be a single sub-module sm_ptr_fifo (push/pop/full/empty/level); sm_res2cmd holds the handshake, filtering and counters.

Verification
REQ-029 The bench SHALL cover: push ok results ptr=3,5,7 with sm_cmd_ready_i=1 -> commands 3,5,7 in order, each one cycle after its push.
REQ-030 The bench SHALL cover: sm_cmd_ready_i=0, 8 ok pushes (FIFO_DEPTH=8) -> level_o=8, sm_res_ready_o=0; 9th result held off; then ready=1 -> 8 commands in order.
REQ-031 The bench SHALL cover: result ok=0 ptr=9 between ok ptr=1 and ptr=2 -> commands 1,2 only; cnt_drop_o=1 and cnt_fwd_o=2 with SM_RES2CMD_CNT_EN.
REQ-032 The bench SHALL cover: level_o=4 with push and pop in the same cycle for 20 cycles -> level_o stays 4, order preserved across pointer wrap.
REQ-033 The bench SHALL cover: flush_i pulse with level_o=5 and a same-cycle push -> level_o=0, sm_cmd_valid_o=0 the next cycle, pushed pointer lost.
REQ-034 The bench SHALL cover: rst_n_i low for half a cycle mid-stream -> outputs clear immediately, and after release no stale command appears.
